// File: rtl/note_recorder_if.sv
// Note-recorder bus: beat strobe, record/play requests and live note in,
// registered note, status LEDs and recorded length out.
interface note_recorder_if #(
    parameter int ADDR_W = 6
);
    logic              _QUARTER_BEAT;
    logic              REC;
    logic              PLAY;
    logic [3:0]        live_note;
    logic [3:0]        note;
    logic [7:0]        Led;
    logic [ADDR_W:0]   length;

    modport master (
        output _QUARTER_BEAT, REC, PLAY, live_note,
        input  note, Led, length
    );

    modport slave (
        input  _QUARTER_BEAT, REC, PLAY, live_note,
        output note, Led, length
    );
endinterface

// File: rtl/note_recorder.sv
// Records a live note stream into a step buffer, one entry per quarter-beat
// tick, and plays it back (optionally looping) on the tone-generator note bus.
module note_recorder #(
    parameter int         ADDR_W    = 6,
    parameter logic [3:0] NONE_CODE = 4'b0000,
    parameter bit         LOOP      = 1'b1
) (
    input  logic           CLK,
    input  logic           RESET,
    note_recorder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RECORD, S_PLAY} state_t;

    state_t          state_q;
    logic            rec_prev_q;
    logic            play_prev_q;
    logic [ADDR_W:0] wptr_q;
    logic [ADDR_W:0] rptr_q;
    logic [ADDR_W:0] length_q;
    logic [3:0]      note_q;
    logic [3:0]      mem_q [DEPTH];

    logic            rec_rise;
    logic            play_rise;
    logic            tick;
    logic            recording;
    logic            playing;
    logic [3:0]      rd_data;
    logic [5:0]      ptr_led;

    assign rec_rise  = bus.REC & ~rec_prev_q;
    assign play_rise = bus.PLAY & ~play_prev_q;
    assign tick      = bus._QUARTER_BEAT;
    assign recording = (state_q == S_ARM) || (state_q == S_RECORD);
    assign playing   = (state_q == S_PLAY);
    assign rd_data   = mem_q[rptr_q[ADDR_W-1:0]];

    // Pointer shown on the LEDs, zero-extended when the pointer is narrower than 6 bits.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_led
            if (gi <= ADDR_W) begin : g_bit
                assign ptr_led[gi] = playing   ? rptr_q[gi] :
                                     recording ? wptr_q[gi] : 1'b0;
            end else begin : g_zero
                assign ptr_led[gi] = 1'b0;
            end
        end
    endgenerate

    assign bus.Led    = {recording, playing, ptr_led};
    assign bus.note   = note_q;
    assign bus.length = length_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            note_q      <= NONE_CODE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            length_q    <= '0;
            rec_prev_q  <= 1'b0;
            play_prev_q <= 1'b0;
        end else begin
            rec_prev_q  <= bus.REC;
            play_prev_q <= bus.PLAY;
            case (state_q)
                S_IDLE: begin
                    note_q <= NONE_CODE;
                    if (rec_rise) begin
                        state_q <= S_ARM;
                        wptr_q  <= '0;
                        note_q  <= bus.live_note;
                    end else if (play_rise && (length_q != '0)) begin
                        state_q <= S_PLAY;
                        rptr_q  <= '0;
                    end
                end
                S_ARM: begin
                    if (!bus.REC) begin
                        state_q <= S_IDLE;
                        note_q  <= NONE_CODE;
                    end else begin
                        note_q <= bus.live_note;
                        if (tick) begin
                            mem_q[0] <= bus.live_note;
                            wptr_q   <= (ADDR_W+1)'(1);
                            state_q  <= S_RECORD;
                        end
                    end
                end
                S_RECORD: begin
                    // REC low wins over a coincident tick: that step is dropped.
                    if (!bus.REC) begin
                        length_q <= wptr_q;
                        state_q  <= S_IDLE;
                        note_q   <= NONE_CODE;
                    end else begin
                        note_q <= bus.live_note;
                        if (tick) begin
                            mem_q[wptr_q[ADDR_W-1:0]] <= bus.live_note;
                            wptr_q <= wptr_q + 1'b1;
                            if (wptr_q == (ADDR_W+1)'(DEPTH - 1)) begin
                                length_q <= (ADDR_W+1)'(DEPTH);
                                state_q  <= S_IDLE;
                                note_q   <= NONE_CODE;
                            end
                        end
                    end
                end
                S_PLAY: begin
                    if (!bus.PLAY) begin
                        state_q <= S_IDLE;
                        note_q  <= NONE_CODE;
                    end else if (tick) begin
                        if (rptr_q < length_q) begin
                            note_q <= rd_data;
                            rptr_q <= rptr_q + 1'b1;
                        end else if (LOOP) begin
                            note_q <= mem_q[0];
                            rptr_q <= (ADDR_W+1)'(1);
                        end else begin
                            note_q  <= NONE_CODE;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    note_q  <= NONE_CODE;
                end
            endcase
        end
    end
endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
Captures a live 4-bit note stream into an on-chip step buffer, one entry per quarter-beat tick, then plays it back on the same `note` / `Led` interface used by the song auto-players. It is the write-side counterpart of the ROM-driven auto-player: the user records a tune, and it replays exactly like a hard-coded song. It sits between the keyboard/switch note decoder and the tone generator mux.

Parameters:
ADDR_W, 6, step-buffer address width; DEPTH = 2^ADDR_W steps (max 64; Led mapping needs ADDR_W <= 6)
NONE_CODE, 4'b0000, note code meaning silence (must match the shared note-parameter `none`)
LOOP, 1, 1 = playback wraps to step 0 after the last step; 0 = playback stops and returns to IDLE

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
_QUARTER_BEAT  in  1  single-CLK-cycle beat strobe, synchronous to CLK
REC  in  1  record request, level; the rising edge starts recording, a low level stops it
PLAY  in  1  play request, level; the rising edge starts playback, a low level stops it
live_note  in  4  current note code from the keyboard decoder
note  out  4  registered note to the tone generator
Led  out  8  [7]=recording (ARM or RECORD), [6]=PLAY state, [5:0]=active pointer zero-extended
length  out  ADDR_W+1  number of valid recorded steps (0..DEPTH)

Behaviour:
- Clock, reset and resources:
  - Single clock domain; all state updates on posedge CLK.
  - RESET (synchronous) forces: state=IDLE, note=NONE_CODE, Led=0, length=0, wptr=0, rptr=0, and clears the REC/PLAY edge-detect registers.
  - Buffer contents are not cleared by reset; with length=0 they are unreachable.
- Edge detection: REC and PLAY rising edges are detected internally, one cycle after sampling.
- States:
  - IDLE: note=NONE_CODE. A REC rise goes to ARM. Otherwise a PLAY rise with length>0 goes to PLAY with rptr=0. A PLAY rise with length=0 is ignored. If REC and PLAY rise in the same cycle, REC wins.
  - ARM: note=live_note (registered monitor). REC low returns to IDLE and length is unchanged. On the first tick: write mem[0]=live_note, set wptr=1, go to RECORD.
  - RECORD: note=live_note.
    - Each tick writes mem[wptr]=live_note and increments wptr.
    - REC low: length<=wptr, go to IDLE (at most one cycle after REC falls). A tick in the same cycle that REC is seen low is not written.
    - Full: the tick that writes index DEPTH-1 sets length<=DEPTH and goes to IDLE, even if REC is still high. A new REC rise is needed to re-record.
  - PLAY:
    - note holds NONE_CODE until the first tick.
    - On each tick with rptr<length: note<=mem[rptr], rptr++.
    - On a tick with rptr==length: if LOOP=1, note<=mem[0] and rptr<=1; if LOOP=0, note<=NONE_CODE and go to IDLE.
    - PLAY low: go to IDLE, and note=NONE_CODE on the next cycle.
    - REC rise is ignored in PLAY.
- Latency: note updates on the CLK edge after the tick strobe (1 cycle).
- A new recording overwrites from index 0. length is updated only when that recording ends.
- Led[5:0] shows wptr in ARM/RECORD, rptr in PLAY, and 0 in IDLE.
- Memory: DEPTH x 4 register array or distributed RAM. Write and read occur only on tick cycles. Reads are combinational and registered into note.

Test Plan:
1. Reset then idle: REC=PLAY=0 and ticks applied -> note=0000, Led=0, length=0 throughout.
2. Record then play:
   - Stimulus: REC rise; 4 ticks with live_note=E,F,G,NONE_CODE; drop REC; PLAY rise, LOOP=1.
   - Required: length=4; note after successive ticks = E,F,G,0000,E,F, one cycle after each tick; Led[6]=1; Led[5:0] = 1,2,3,4,1,2.
3. Full buffer: hold REC high for 70 ticks -> length=64 after the 64th tick; state returns to IDLE (Led[7]=0); ticks 65–70 write nothing.
4. Empty play and priority:
   - PLAY rise with length=0 -> stays IDLE, note=0000.
   - REC and PLAY rising in the same cycle -> ARM (Led[7]=1, Led[6]=0).
5. LOOP=0 end: record 3 steps, play -> note sequence s0,s1,s2, then 0000 on the 4th tick; Led=0 afterwards.
6. Reset mid-operation: RESET during RECORD at wptr=10, and separately during PLAY -> the next cycle shows length=0, note=0000, Led=0; a following PLAY rise is ignored.
